// File: rtl/clk_div_gen_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Optional start-phase support is enabled by defining CLK_DIV_GEN_PHASE_EN.
package clk_div_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        RUN
    } ch_state_e;

    localparam int unsigned DIV_MIN = 2;

    // high <= div-1 and phase <= div-1 are written as strict compares to avoid any wrap.
    function automatic logic cfg_valid(input int unsigned d,
                                       input int unsigned h,
                                       input int unsigned p,
                                       input logic        chk_phase);
        return (d >= DIV_MIN) && (h >= 1) && (h < d) && (!chk_phase || (p < d));
    endfunction

endpackage

// File: rtl/clk_div_gen_ch.sv
// One divided-clock channel: FSM, period counter, shadow config and registered outputs.
// With CLK_DIV_GEN_PHASE_EN undefined the DELAY state and phase shadow are removed.
module clk_div_gen_ch
    import clk_div_gen_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [DIV_W-1:0] high_i,
    input  logic [DIV_W-1:0] phase_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             active_o,
    output logic             cfg_err_o
);

`ifdef CLK_DIV_GEN_PHASE_EN
    localparam logic PhaseEn = 1'b1;
    logic [DIV_W-1:0] phase_q, phase_d;
`else
    localparam logic PhaseEn = 1'b0;
`endif

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] high_q, high_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             active_q, active_d;
    logic             cfg_err_q, cfg_err_d;
    logic             start_ok, reload_ok;

    // Phase only matters when starting from IDLE; it is ignored on period reloads.
    assign start_ok  = cfg_valid(32'(div_i), 32'(high_i), 32'(phase_i), PhaseEn);
    assign reload_ok = cfg_valid(32'(div_i), 32'(high_i), 32'(phase_i), 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            high_q    <= '0;
`ifdef CLK_DIV_GEN_PHASE_EN
            phase_q   <= '0;
`endif
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            active_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            high_q    <= high_d;
`ifdef CLK_DIV_GEN_PHASE_EN
            phase_q   <= phase_d;
`endif
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            active_q  <= active_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        high_d    = high_q;
`ifdef CLK_DIV_GEN_PHASE_EN
        phase_d   = phase_q;
`endif
        cfg_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    if (start_ok) begin
                        div_d  = div_i;
                        high_d = high_i;
                        cnt_d  = '0;
`ifdef CLK_DIV_GEN_PHASE_EN
                        phase_d = phase_i;
                        state_d = (phase_i == '0) ? RUN : DELAY;
`else
                        state_d = RUN;
`endif
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
`ifdef CLK_DIV_GEN_PHASE_EN
            DELAY: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (cnt_q == phase_q - 1'b1) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            RUN: begin
                if (cnt_q == div_q - 1'b1) begin
                    if (!en_i) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = '0;
                        if (reload_ok) begin
                            div_d  = div_i;
                            high_d = high_i;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state register.
    always_comb begin
        clk_out_d = (state_d == RUN) && (cnt_d < high_d);
        tick_d    = (state_d == RUN) && (cnt_d == '0);
        active_d  = (state_d != IDLE);
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign active_o  = active_q;
    assign cfg_err_o = cfg_err_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider; one clk_div_gen_ch per channel.
// Define CLK_DIV_GEN_PHASE_EN to enable per-channel start phase.
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*DIV_W-1:0] div,
    input  logic [NUM_CH*DIV_W-1:0] high,
    input  logic [NUM_CH*DIV_W-1:0] phase,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       active,
    output logic [NUM_CH-1:0]       cfg_err
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_gen_ch #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_i     (en[i]),
            .div_i    (div[i*DIV_W +: DIV_W]),
            .high_i   (high[i*DIV_W +: DIV_W]),
            .phase_i  (phase[i*DIV_W +: DIV_W]),
            .clk_out_o(clk_out[i]),
            .tick_o   (tick[i]),
            .active_o (active[i]),
            .cfg_err_o(cfg_err[i])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen: vector table on channel 0 plus
// hand sequences for phase, reload, stop, glitch-free re-enable and async reset.
module tb_clk_div_gen;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*DIV_W-1:0] div, high, phase;
    logic [NUM_CH-1:0]       clk_out, tick, active, cfg_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [7:0] dv;
        logic [7:0] hi;
        logic [3:0] exp; // {clk_out, tick, active, cfg_err}
    } vec_t;

    vec_t vecs[$];

    logic [NUM_CH-1:0] co_h[64];
    logic [NUM_CH-1:0] tk_h[64];
    logic [NUM_CH-1:0] ac_h[64];

    clk_div_gen #(
        .NUM_CH(NUM_CH),
        .DIV_W (DIV_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .div    (div),
        .high   (high),
        .phase  (phase),
        .clk_out(clk_out),
        .tick   (tick),
        .active (active),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input int d, input int h, input logic [3:0] x);
        vec_t v;
        v.en  = e;
        v.dv  = 8'(d);
        v.hi  = 8'(h);
        v.exp = x;
        vecs.push_back(v);
    endtask

    task automatic set_ch(input int c, input logic e, input int d, input int h, input int p);
        en[c]                = e;
        div[c*DIV_W +: DIV_W]   = DIV_W'(d);
        high[c*DIV_W +: DIV_W]  = DIV_W'(h);
        phase[c*DIV_W +: DIV_W] = DIV_W'(p);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = '0;
        div   = '0;
        high  = '0;
        phase = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic record(input int i);
        co_h[i] = clk_out;
        tk_h[i] = tick;
        ac_h[i] = active;
    endtask

    // kind: 0 = clk_out, 1 = tick, 2 = active; bit i of the result is cycle i.
    function automatic logic [31:0] hist(input int c, input int n, input int kind);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) begin
            case (kind)
                0:       r[i] = co_h[i][c];
                1:       r[i] = tk_h[i][c];
                default: r[i] = ac_h[i][c];
            endcase
        end
        return r;
    endfunction

    initial begin
        logic [31:0] exp0, exp1;
        int          off1;

        // Reset state
        rst_n = 1'b0;
        en    = '0;
        div   = '0;
        high  = '0;
        phase = '0;
        #12;
        check("reset_clk_out", 32'(clk_out), 32'h0);
        check("reset_tick",    32'(tick),    32'h0);
        check("reset_active",  32'(active),  32'h0);
        check("reset_cfg_err", 32'(cfg_err), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // div=4 high=2: 1,1,0,0 with tick every 4, then stop at the boundary
        for (int i = 0; i < 2; i++) begin
            add(1, 4, 2, 4'b1110);
            add(1, 4, 2, 4'b1010);
            add(1, 4, 2, 4'b0010);
            add(1, 4, 2, 4'b0010);
        end
        add(0, 4, 2, 4'b0000);
        // high == div is rejected until high is fixed
        add(1, 5, 5, 4'b0001);
        add(1, 5, 5, 4'b0001);
        add(1, 5, 2, 4'b1110);
        add(1, 5, 2, 4'b1010);
        add(1, 5, 2, 4'b0010);
        add(1, 5, 2, 4'b0010);
        add(1, 5, 2, 4'b0010);
        add(0, 5, 2, 4'b0000);
        // div below the minimum and high == 0
        add(1, 1, 1, 4'b0001);
        add(1, 4, 0, 4'b0001);
        add(0, 4, 2, 4'b0000);
        // minimum legal div=2 high=1; mid-period drop waits for the boundary
        add(1, 2, 1, 4'b1110);
        add(1, 2, 1, 4'b0010);
        add(1, 2, 1, 4'b1110);
        add(0, 2, 1, 4'b0010);
        add(0, 2, 1, 4'b0000);
        // invalid reload keeps the old config and pulses cfg_err
        add(1, 4, 2, 4'b1110);
        add(1, 4, 2, 4'b1010);
        add(1, 4, 2, 4'b0010);
        add(1, 4, 2, 4'b0010);
        add(1, 4, 4, 4'b1111);
        add(1, 4, 2, 4'b1010);
        add(1, 4, 2, 4'b0010);
        add(1, 4, 2, 4'b0010);
        add(0, 4, 2, 4'b0000);

        foreach (vecs[i]) begin
            set_ch(0, vecs[i].en, int'(vecs[i].dv), int'(vecs[i].hi), 0);
            @(posedge clk);
            #2;
            check($sformatf("vec[%0d]", i), 32'({clk_out[0], tick[0], active[0], cfg_err[0]}),
                  32'(vecs[i].exp));
        end

        // Two channels, same div, ch1 delayed by phase 5
        do_reset();
        set_ch(0, 1, 8, 3, 0);
        set_ch(1, 1, 8, 3, 5);
`ifdef CLK_DIV_GEN_PHASE_EN
        off1 = 5;
`else
        off1 = 0;
`endif
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            record(i);
        end
        exp0 = '0;
        exp1 = '0;
        for (int i = 0; i < 20; i++) begin
            exp0[i] = ((i % 8) < 3);
            exp1[i] = (i >= off1) && (((i - off1) % 8) < 3);
        end
        check("phase_ch0_clk_out", hist(0, 20, 0), exp0);
        check("phase_ch1_clk_out", hist(1, 20, 0), exp1);
        check("phase_ch1_active0", 32'(ac_h[0][1]), 32'h1);

        // phase == div is only rejected when phase support is present
        do_reset();
        set_ch(2, 1, 8, 3, 8);
        @(posedge clk);
        #2;
`ifdef CLK_DIV_GEN_PHASE_EN
        check("phase_limit", 32'({active[2], cfg_err[2]}), 32'b01);
`else
        check("phase_limit", 32'({active[2], cfg_err[2]}), 32'b10);
`endif

        // div=6 high=3, div changed to 10 at k=2 takes effect next period
        do_reset();
        set_ch(0, 1, 6, 3, 0);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #2;
            record(i);
            if (i == 2) set_ch(0, 1, 10, 3, 0);
        end
        check("reload_clk_out", hist(0, 17, 0), 32'h101C7);
        check("reload_tick",    hist(0, 17, 1), 32'h10041);

        // div=6 high=4, en dropped at k=1: full high pulse, active falls after k=5
        do_reset();
        set_ch(0, 1, 6, 4, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #2;
            record(i);
            if (i == 1) en[0] = 1'b0;
        end
        check("stop_clk_out", hist(0, 8, 0), 32'h0F);
        check("stop_active",  hist(0, 8, 2), 32'h3F);

        // en pulsed low at k=1 and restored at k=2: unbroken output
        do_reset();
        set_ch(0, 1, 6, 4, 0);
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #2;
            record(i);
            if (i == 1) en[0] = 1'b0;
            if (i == 2) en[0] = 1'b1;
        end
        check("glitch_clk_out", hist(0, 13, 0), 32'h13CF);
        check("glitch_active",  hist(0, 13, 2), 32'h1FFF);

        // Async reset during a high phase, then restart with en held
        do_reset();
        set_ch(0, 1, 4, 2, 0);
        set_ch(1, 1, 5, 5, 0);
        @(posedge clk);
        #2;
        check("pre_rst_state", 32'({clk_out[0], active[0], cfg_err[1]}), 32'b111);
        rst_n = 1'b0;
        #1;
        check("async_rst_clk_out", 32'(clk_out), 32'h0);
        check("async_rst_tick",    32'(tick),    32'h0);
        check("async_rst_active",  32'(active),  32'h0);
        check("async_rst_cfg_err", 32'(cfg_err), 32'h0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("restart_k0", 32'({clk_out[0], tick[0], active[0], cfg_err[0]}), 32'b1110);
        @(posedge clk);
        #2;
        check("restart_k1", 32'({clk_out[0], tick[0], active[0], cfg_err[0]}), 32'b1010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Synthesisable, multi-channel successor to the behavioural clock generator. It derives `NUM_CH` independent divided clocks from one system clock. Each channel has a programmable period, high time (duty cycle) and start phase, all counted in system-clock cycles. Outputs are registered and glitch-free. Configuration changes take effect only on period boundaries, and stop requests are honoured at the end of the current period. The block feeds test-clock and strobe generation in the datapath tiles.

## Interface
- `NUM_CH`, default 4: number of output channels.
- `DIV_W`, default 8: width of each per-channel period, high and phase field.

Ports:
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `en` input, `NUM_CH` bits: per-channel run request.
- `div` input, `NUM_CH*DIV_W` bits: period in clk cycles. Channel i occupies `[i*DIV_W +: DIV_W]`.
- `high` input, `NUM_CH*DIV_W` bits: high time in clk cycles.
- `phase` input, `NUM_CH*DIV_W` bits: delay in clk cycles before the first period.
- `clk_out` output, `NUM_CH` bits: divided clock, registered.
- `tick` output, `NUM_CH` bits: one-cycle pulse on period cycle 0.
- `active` output, `NUM_CH` bits: high when the channel is not IDLE.
- `cfg_err` output, `NUM_CH` bits: configuration rejected.

## Operation
Each channel runs independently as a 3-state FSM: IDLE, DELAY, RUN.

Validity check:
- A config is valid iff `div>=2`, `1<=high<=div-1` and `phase<=div-1`.
- All arithmetic is unsigned `DIV_W`-bit. There is no wrap.

Shadow registers hold `div`, `high` and `phase`. Inputs are sampled only at the points listed below.

IDLE:
- Outputs: `clk_out=0`, `tick=0`, `active=0`.
- On an edge with `en=1` and a valid config:
  - Load the shadow registers.
  - Go to RUN if `phase==0`, otherwise go to DELAY.
- On an edge with `en=1` and an invalid config:
  - Stay in IDLE.
  - Drive `cfg_err=1` on the next cycle.
  - The check is re-evaluated every cycle.

DELAY:
- Count `phase` cycles with `clk_out=0`, then enter RUN at period cycle k=0.
- If `en=0` is sampled, return to IDLE immediately.

RUN:
- Period cycle index k runs from 0 to `div-1`.
- `clk_out=1` for k<`high`, else 0.
- `tick=1` only at k=0.

At k=`div-1` (the period boundary):
- If `en=0`, go to IDLE. `clk_out` is already low, so there is no truncated high pulse.
- Otherwise, re-sample the inputs:
  - Valid config: load the shadow registers. Phase is ignored on reload.
  - Invalid config: keep the old shadow values and pulse `cfg_err` for 1 cycle.
- Deasserting `en` in the middle of a period and reasserting it before the boundary has no effect on the output.

Other rules:
- Input changes between boundaries are ignored.
- Reset in the middle of operation: all channels go to IDLE and all outputs drop to 0 asynchronously. No partial period resumes after `rst_n` rises.

## Timing
- Reset value of every output is 0.
- Start latency: `en` sampled at edge E0 with `phase=0` gives `clk_out=1` and `tick=1` from edge E0+1. With `phase=p`, this moves to E0+1+p.
- Output period is exactly `div` cycles and high time is exactly `high` cycles.
- Stop latency: `active` falls on the edge after the boundary cycle.
- `cfg_err` appears 1 cycle after the sampling edge.
- Channels are mutually phase-locked when they are enabled on the same edge with the same `div`.

## Configuration
- `CLK_DIV_GEN_PHASE_EN` defined: behaviour is exactly as specified above, including the DELAY state.
- Not defined:
  - The DELAY state and the phase shadow register are removed.
  - The `phase` port remains but is ignored.
  - `phase` never contributes to `cfg_err`.
  - Start latency is always 1 cycle.

## Structure
- Package `clk_div_gen_pkg`:
  - state enum `{IDLE, DELAY, RUN}`
  - the localparam `DIV_MIN=2`
  - a config-valid check function
- Sub-module `clk_div_gen_ch`: one channel, holding the FSM, counter, shadow registers and output registers.
- The top level instantiates `clk_div_gen_ch` once per channel via a generate loop and slices the buses.

## Test plan
- div=4, high=2, phase=0, en rises and is sampled at E0:
  - `clk_out` reads 1,1,0,0 repeating from E0+1.
  - `tick` pulses every 4 cycles.
- Two channels at div=8, high=3; ch0 phase=0, ch1 phase=5, enabled on the same edge:
  - ch1 rises exactly 5 cycles after ch0.
  - With the macro undefined, both channels rise together.
- div=6, high=3 running; div changed to 10 at period cycle k=2:
  - The current period completes at 6 cycles.
  - The next period is 10 cycles with a 3-cycle high time.
- div=5, high=5, en=1 from IDLE:
  - Channel stays IDLE with `cfg_err=1`.
  - After high is changed to 2, the channel starts the next cycle.
- div=6, high=4 running; en dropped at k=1:
  - The 4-cycle high pulse is intact.
  - `active` falls after k=5.
  - en pulsed low at k=1 then restored at k=2 gives an unbroken output.
- `rst_n` asserted in the middle of a high phase:
  - `clk_out`, `tick`, `active` and `cfg_err` go to 0 immediately.
  - After release with en=1, the channel restarts with its full start latency.
